pixel_row_streamer: RTL and testbench

- Parametrised successor to the fixed 12x24, 8-bit, 8-wide pixel readout.
- Accepts one full pixel row per handshake from the pixel-array readout side.
- Buffers the row in a two-entry ping-pong buffer.
- Streams the row out as beats of BUS_PIXELS pixels with frame and line markers.
- Sits between the pixel-array ADC/readout state machine and the output bus / image capture bench.

---
 rtl/pixel_row_streamer_pkg.sv | 31 +++
 rtl/pixel_row_buffer.sv | 48 ++++
 rtl/pixel_row_streamer.sv | 158 +++++++++++++++
 tb/tb_pixel_row_streamer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_row_streamer_pkg.sv
// Shared configuration for the pixel row streamer: sensor defaults, derived beat
// constants, pixel/beat types and the output FSM state encoding.
package PixelStreamConfig;

   localparam int DEF_WIDTH      = 24;
   localparam int DEF_HEIGHT     = 12;
   localparam int DEF_PIXEL_BITS = 8;
   localparam int DEF_BUS_PIXELS = 8;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Counters for a range of one still need a single bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BEATS            = ceil_div(DEF_WIDTH, DEF_BUS_PIXELS);
   localparam int LAST_BEAT_PIXELS = DEF_WIDTH - (BEATS - 1) * DEF_BUS_PIXELS;

   typedef logic [DEF_PIXEL_BITS-1:0]                pixel_t;
   typedef logic [DEF_BUS_PIXELS*DEF_PIXEL_BITS-1:0] beat_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM
   } stream_state_t;

endpackage

// File: rtl/pixel_row_buffer.sv
// Two-entry ping-pong row store with write/read pointers and occupancy count.
module pixel_row_buffer
   import PixelStreamConfig::*;
#(
   parameter int ROW_BITS = DEF_WIDTH * DEF_PIXEL_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [ROW_BITS-1:0] wr_data,
   input  logic                rd_done,
   output logic [ROW_BITS-1:0] rd_data,
   output logic [1:0]          occupancy,
   output logic                wr_ready
);

   logic [ROW_BITS-1:0] mem [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic                wr_fire;

   assign wr_ready = (occupancy != 2'd2);
   assign wr_fire  = wr_en && wr_ready;
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         if (wr_fire) wr_ptr <= ~wr_ptr;
         if (rd_done) rd_ptr <= ~rd_ptr;
         unique case ({wr_fire, rd_done})
            2'b10:   occupancy <= occupancy + 2'd1;
            2'b01:   occupancy <= occupancy - 2'd1;
            default: ;
         endcase
      end
   end

   // NOTE: the row storage has no reset; occupancy gates every read, so stale
   // contents are never observed and the wide array stays plain RAM.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/pixel_row_streamer.sv
// Accepts whole pixel rows, buffers two, streams them as BUS_PIXELS-wide beats
// with sof/eol/eof markers. PIXEL_STREAM_TEST_PATTERN_EN adds a test_mode pattern source.
module pixel_row_streamer
   import PixelStreamConfig::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int PIXEL_BITS = DEF_PIXEL_BITS,
   parameter int BUS_PIXELS = DEF_BUS_PIXELS
) (
   input  logic                             clk,
   input  logic                             reset,
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
   input  logic                             test_mode,
`endif
   input  logic                             row_valid,
   output logic                             row_ready,
   input  logic [WIDTH*PIXEL_BITS-1:0]      row_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [BUS_PIXELS*PIXEL_BITS-1:0] out_data,
   output logic [BUS_PIXELS-1:0]            out_keep,
   output logic                             out_sof,
   output logic                             out_eol,
   output logic                             out_eof,
   output logic                             overflow
);

   localparam int ROW_BITS  = WIDTH * PIXEL_BITS;
   localparam int BEAT_BITS = BUS_PIXELS * PIXEL_BITS;
   localparam int NUM_BEATS = ceil_div(WIDTH, BUS_PIXELS);
   localparam int PAD_BITS  = NUM_BEATS * BEAT_BITS;
   localparam int BEAT_W    = cnt_width(NUM_BEATS);
   localparam int ROW_W     = cnt_width(HEIGHT);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

   stream_state_t       state;
   stream_state_t       state_n;
   logic [BEAT_W-1:0]   beat;
   logic [ROW_W-1:0]    row_cnt;
   logic [ROW_BITS-1:0] wr_data;
   logic [ROW_BITS-1:0] rd_data;
   logic [1:0]          occupancy;
   logic                row_fire;
   logic                beat_fire;
   logic                last_fire;
   logic [15:0]         stall_cnt;
   logic                stall;

   assign row_fire  = row_valid && row_ready;
   assign out_valid = (state != IDLE);
   assign beat_fire = out_valid && out_ready;
   assign last_fire = beat_fire && (beat == LAST_BEAT);

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
   logic [ROW_W-1:0]    wr_row;
   logic [ROW_BITS-1:0] pattern;

   always_ff @(posedge clk) begin
      if (reset)         wr_row <= '0;
      else if (row_fire) wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + 1'b1;
   end

   always_comb begin
      pattern = '0;
      for (int c = 0; c < WIDTH; c++)
         pattern[c*PIXEL_BITS +: PIXEL_BITS] = PIXEL_BITS'(int'(wr_row) + c);
      wr_data = test_mode ? pattern : row_data;
   end
`else
   assign wr_data = row_data;
`endif

   pixel_row_buffer #(
      .ROW_BITS (ROW_BITS)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (row_valid),
      .wr_data   (wr_data),
      .rd_done   (last_fire),
      .rd_data   (rd_data),
      .occupancy (occupancy),
      .wr_ready  (row_ready)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (row_fire) state_n = LOAD;
         LOAD, STREAM: begin
            if (beat_fire) begin
               if (beat == LAST_BEAT)
                  // Another row already buffered (or arriving now) follows with no bubble.
                  state_n = (occupancy == 2'd2 || row_fire) ? LOAD : IDLE;
               else
                  state_n = STREAM;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat    <= '0;
         row_cnt <= '0;
      end else if (beat_fire) begin
         if (beat == LAST_BEAT) begin
            beat    <= '0;
            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

   // Zero-padding the row to whole beats makes the pixels past WIDTH read as 0.
   logic [PAD_BITS-1:0]   row_pad;
   logic [BEAT_BITS-1:0]  beat_data;
   logic [BUS_PIXELS-1:0] beat_keep;

   always_comb begin
      row_pad   = PAD_BITS'(rd_data);
      beat_data = row_pad[int'(beat)*BEAT_BITS +: BEAT_BITS];
      beat_keep = '0;
      for (int i = 0; i < BUS_PIXELS; i++)
         beat_keep[i] = (int'(beat) * BUS_PIXELS + i) < WIDTH;
   end

   assign out_data = out_valid ? beat_data : '0;
   assign out_keep = out_valid ? beat_keep : '0;
   assign out_sof  = out_valid && (row_cnt == '0) && (beat == '0);
   assign out_eol  = out_valid && (beat == LAST_BEAT);
   assign out_eof  = out_eol && (row_cnt == LAST_ROW);

   assign stall = row_valid && !row_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (!stall)                    stall_cnt <= '0;
         else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (stall_cnt == 16'hFFFF)     overflow  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pixel_row_streamer.sv
// Self-checking bench: queue-based reference model on the default instance plus a
// vector table on a 20-pixel-wide instance for partial last beats.
module tb_pixel_row_streamer;
   import PixelStreamConfig::*;

   localparam int W  = 24;
   localparam int H  = 12;
   localparam int PB = 8;
   localparam int BP = 8;
   localparam int NB = (W + BP - 1) / BP;
   localparam int W2 = 20;
   localparam int H2 = 2;

   typedef logic [W*PB-1:0] row_t;

   logic clk = 1'b0;
   logic reset;
   logic row_valid, row_ready, out_valid, out_ready;
   row_t row_data;
   logic [BP*PB-1:0] out_data;
   logic [BP-1:0]    out_keep;
   logic out_sof, out_eol, out_eof, overflow;

   logic row_valid2, row_ready2, out_valid2, out_ready2;
   logic [W2*PB-1:0] row_data2;
   logic [BP*PB-1:0] out_data2;
   logic [BP-1:0]    out_keep2;
   logic out_sof2, out_eol2, out_eof2, overflow2;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
   logic test_mode;
   logic test_mode2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pixel_row_streamer dut (
      .clk(clk), .reset(reset),
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_sof(out_sof), .out_eol(out_eol),
      .out_eof(out_eof), .overflow(overflow)
   );

   pixel_row_streamer #(.WIDTH(W2), .HEIGHT(H2), .PIXEL_BITS(PB), .BUS_PIXELS(BP)) dut2 (
      .clk(clk), .reset(reset),
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
      .test_mode(test_mode2),
`endif
      .row_valid(row_valid2), .row_ready(row_ready2), .row_data(row_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_keep(out_keep2), .out_sof(out_sof2), .out_eol(out_eol2),
      .out_eof(out_eof2), .overflow(overflow2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] exp_beat(input row_t r, input int b);
      logic [63:0] d = '0;
      for (int i = 0; i < BP; i++)
         if (b * BP + i < W) d[i*PB +: PB] = r[(b*BP+i)*PB +: PB];
      return d;
   endfunction

   function automatic logic [7:0] exp_keep(input int b);
      logic [7:0] k = '0;
      for (int i = 0; i < BP; i++) k[i] = (b * BP + i < W);
      return k;
   endfunction

   function automatic row_t pattern_row(input int r);
      row_t p;
      for (int c = 0; c < W; c++) p[c*PB +: PB] = 8'((r + c) % 256);
      return p;
   endfunction

   row_t q[$];
   int   mrow = 0, mbeat = 0, wrow = 0;
   int   beats_seen = 0, sof_seen = 0, eof_seen = 0, accepted = 0, valid_cycles = 0;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         mrow = 0; mbeat = 0; wrow = 0;
      end else begin
         check("row_ready", row_ready, q.size() < 2);
         check("out_valid", out_valid, q.size() > 0);
         check("overflow", overflow, 1'b0);
         if (out_valid && q.size() > 0) begin
            valid_cycles++;
            check("beat_data", out_data, exp_beat(q[0], mbeat));
            check("beat_keep", out_keep, exp_keep(mbeat));
            check("sof", out_sof, (mrow == 0 && mbeat == 0));
            check("eol", out_eol, (mbeat == NB - 1));
            check("eof", out_eof, (mbeat == NB - 1 && mrow == H - 1));
            if (out_ready) begin
               beats_seen++;
               if (mrow == 0 && mbeat == 0) sof_seen++;
               if (mbeat == NB - 1) begin
                  if (mrow == H - 1) eof_seen++;
                  void'(q.pop_front());
                  mbeat = 0;
                  mrow  = (mrow + 1) % H;
               end else begin
                  mbeat++;
               end
            end
         end else if (!out_valid) begin
            check("idle_data", out_data, 64'h0);
            check("idle_flags", {out_keep, out_sof, out_eol, out_eof}, 11'h0);
         end
         if (row_valid && row_ready) begin
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
            q.push_back(test_mode ? pattern_row(wrow) : row_data);
`else
            q.push_back(row_data);
`endif
            wrow = (wrow + 1) % H;
            accepted++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      row_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Leaves row_valid high on return so callers can chain rows back to back.
   task automatic send_row(input row_t d);
      bit done = 0;
      row_data  = d;
      row_valid = 1'b1;
      for (int n = 0; n < 400 && !done; n++) begin
         @(negedge clk);
         if (row_ready) done = 1;
         tick();
      end
      if (!done) check("send_row_timeout", 1'b0, 1'b1);
   endtask

   task automatic drain();
      bit done = 0;
      row_valid = 1'b0;
      for (int n = 0; n < 800 && !done; n++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) done = 1;
         tick();
      end
      if (!done) check("drain_timeout", 1'b0, 1'b1);
   endtask

   function automatic row_t rand_row();
      row_t d;
      for (int k = 0; k < W * PB / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   typedef struct {
      logic        rdy;
      logic        vld;
      logic [63:0] data;
      logic [7:0]  keep;
      logic [2:0]  flags;   // {sof, eol, eof}
   } vec_t;

   vec_t tab[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base, acc_base;
      bit   found;
      row_t d;

      tab[0] = '{1'b0, 1'b1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 3'b100};
      tab[1] = '{1'b1, 1'b1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 3'b100};
      tab[2] = '{1'b1, 1'b1, 64'hAFAEADACABAAA9A8, 8'hFF, 3'b000};
      tab[3] = '{1'b0, 1'b1, 64'h00000000B3B2B1B0, 8'h0F, 3'b010};
      tab[4] = '{1'b1, 1'b1, 64'h00000000B3B2B1B0, 8'h0F, 3'b010};
      tab[5] = '{1'b1, 1'b0, 64'h0,                8'h00, 3'b000};

      reset = 1'b1;
      row_valid = 1'b0; row_data = '0; out_ready = 1'b1;
      row_valid2 = 1'b0; row_data2 = '0; out_ready2 = 1'b1;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
      test_mode = 1'b0; test_mode2 = 1'b0;
`endif
      repeat (3) tick();
      reset = 1'b0;

      // Reset values.
      @(negedge clk);
      check("rst_row_ready", row_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_flags", {out_sof, out_eol, out_eof, overflow}, 4'h0);
      check("rst_data", out_data, 64'h0);
      check("rst_keep", out_keep, 8'h00);
      tick();

      // Partial last beat on the 20-pixel instance.
      for (int c = 0; c < W2; c++) row_data2[c*PB +: PB] = 8'(8'hA0 + c);
      row_valid2 = 1'b1;
      @(negedge clk);
      check("w20_row_ready", row_ready2, 1'b1);
      tick();
      row_valid2 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         out_ready2 = tab[i].rdy;
         @(negedge clk);
         check($sformatf("tab%0d_valid", i), out_valid2, tab[i].vld);
         check($sformatf("tab%0d_data", i), out_data2, tab[i].data);
         check($sformatf("tab%0d_keep", i), out_keep2, tab[i].keep);
         check($sformatf("tab%0d_flags", i), {out_sof2, out_eol2, out_eof2}, tab[i].flags);
         tick();
      end

      // One full frame, continuous row_valid, out_ready=1: no bubbles.
      base = beats_seen; sof_seen = 0; eof_seen = 0; valid_cycles = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) d[c*PB +: PB] = 8'(r * W + c);
         send_row(d);
      end
      drain();
      check("frame_beats", beats_seen - base, 36);
      check("frame_valid_cycles", valid_cycles, 36);
      check("frame_sof_count", sof_seen, 1);
      check("frame_eof_count", eof_seen, 1);

      // Mid-row stall, then three rows offered back to back.
      base = beats_seen;
      out_ready = 1'b1;
      send_row(rand_row());
      row_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      repeat (5) tick();
      acc_base = accepted;
      fork
         begin
            send_row(rand_row());
            send_row(rand_row());
            send_row(rand_row());
            row_valid = 1'b0;
         end
         begin
            repeat (4) tick();
            @(negedge clk);
            check("stall_row_ready", row_ready, 1'b0);
            check("stall_rows_accepted", accepted - acc_base, 1);
            tick();
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_beats", beats_seen - base, 4 * NB);

      // Randomised gaps and backpressure.
      base = beats_seen;
      begin
         bit rnd_done = 0;
         fork
            begin
               for (int n = 0; n < 40; n++) begin
                  row_valid = 1'b0;
                  repeat ($urandom_range(0, 3)) tick();
                  send_row(rand_row());
               end
               row_valid = 1'b0;
               rnd_done = 1;
            end
            begin
               while (!rnd_done) begin
                  out_ready = ($urandom_range(0, 9) < 7);
                  tick();
               end
               out_ready = 1'b1;
            end
         join
      end
      drain();
      check("random_beats", beats_seen - base, 40 * NB);

      // Reset on beat 1 of row 3, then the next row must carry sof.
      do_reset();
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) send_row(rand_row());
      row_valid = 1'b0;
      found = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         if (mrow == 3 && mbeat == 1) found = 1;
         else tick();
      end
      check("reset_point_found", found, 1'b1);
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("midrst_valid_ready", {out_valid, row_ready}, 2'b01);
      check("midrst_flags", {out_sof, out_eol, out_eof, overflow}, 4'h0);
      check("midrst_data_keep", {out_data[55:0], out_keep}, 64'h0);
      tick();
      reset = 1'b0;
      send_row(rand_row());
      row_valid = 1'b0;
      @(negedge clk);
      check("post_reset_sof", {out_valid, out_sof}, 2'b11);
      tick();
      drain();

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
      do_reset();
      test_mode = 1'b1;
      for (int r = 0; r < 3; r++) send_row(rand_row());
      row_valid = 1'b0;
      test_mode = 1'b0;
      found = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         if (mrow == 2 && mbeat == 0) found = 1;
         else tick();
      end
      check("pattern_point_found", found, 1'b1);
      @(negedge clk);
      check("pattern_row2_beat0", out_data, 64'h0908070605040302);
      tick();
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
